// File: rtl/uart_core.sv
// uart_core: full-duplex UART with internal TX/RX FIFOs, a 2-flop RX
// synchroniser, mid-bit RX sampling and sticky framing/overrun flags.
// Optional feature: define UART_PARITY_EN to add a parity bit
// (sense chosen by PARITY_ODD); otherwise o_parity_err is tied to 0.

// Synchronous FIFO with show-ahead head, extra pointer bit for full/empty.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_write,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_read,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_write;
   logic             do_read;

   assign o_empty  = (wr_ptr_q == rd_ptr_q);
   assign o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A read in the same cycle frees the slot a write into a full FIFO needs.
   assign do_write = i_write && (!o_full || i_read);
   assign do_read  = i_read && !o_empty;
   // An empty FIFO presents zero instead of stale storage.
   assign o_rdata  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Advance each pointer on an accepted access; wrap-around is natural.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_write) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_read)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: sequential state uses <= so every flop sees pre-edge values.
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write.
   // NOTE: storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge i_clk) begin
      if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
   end
endmodule

module uart_core #(
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned CYCLES_PER_BIT = 108,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned PARITY_ODD     = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_write,
   output logic                 o_tx_full,
   output logic                 o_tx_idle,
   output logic [DATA_BITS-1:0] o_rx_data,
   input  logic                 i_rx_read,
   output logic                 o_rx_empty,
   input  logic                 i_err_clr,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_parity_err,
   output logic                 o_tx_w,
   input  logic                 i_rx_w
);
   localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
   localparam logic PAR_SENSE = (PARITY_ODD != 0);
`endif

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_WAIT
   } rx_state_e;

   // ---------------- TX path ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_BITS-1:0] tx_fifo_data;
   logic                 tx_empty;
   logic                 tx_done;
   logic                 tx_pop;
`ifdef UART_PARITY_EN
   logic                 tx_par_q, tx_par_d;
`endif

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_write (i_tx_write),
      .i_wdata (i_tx_data),
      .i_read  (tx_pop),
      .o_rdata (tx_fifo_data),
      .o_full  (o_tx_full),
      .o_empty (tx_empty)
   );

   assign tx_done   = (tx_baud_q == '0);
   assign o_tx_idle = tx_empty && (tx_state_q == TX_IDLE);

   // TX state register and datapath flops.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   // TX next state: each bit lasts BIT_RELOAD+1 clocks; a pop loads a new frame.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      if (tx_state_q != TX_IDLE) tx_baud_d = tx_baud_q - CNT_W'(1);
      case (tx_state_q)
         TX_IDLE: ;
         TX_START: if (tx_done) begin
            tx_state_d = TX_DATA;
            tx_baud_d  = BIT_RELOAD;
            tx_bit_d   = '0;
         end
         TX_DATA: if (tx_done) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_baud_d  = BIT_RELOAD;
            if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
               tx_state_d = TX_PARITY;
`else
               tx_state_d = TX_STOP;
`endif
            end else begin
               tx_bit_d = tx_bit_q + BIT_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: if (tx_done) begin
            tx_state_d = TX_STOP;
            tx_baud_d  = BIT_RELOAD;
         end
`endif
         TX_STOP: if (tx_done) tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
      // Popping from IDLE or at the end of STOP starts the next frame with no gap.
      if (tx_pop) begin
         tx_state_d = TX_START;
         tx_baud_d  = BIT_RELOAD;
         tx_shift_d = tx_fifo_data;
`ifdef UART_PARITY_EN
         tx_par_d   = (^tx_fifo_data) ^ PAR_SENSE;
`endif
      end
   end

   // TX outputs: FIFO pop request and serial line level.
   always_comb begin
      tx_pop = 1'b0;
      o_tx_w = 1'b1;
      case (tx_state_q)
         TX_IDLE:   tx_pop = !tx_empty;
         TX_START:  o_tx_w = 1'b0;
         TX_DATA:   o_tx_w = tx_shift_q[0];
`ifdef UART_PARITY_EN
         TX_PARITY: o_tx_w = tx_par_q;
`endif
         TX_STOP:   tx_pop = tx_done && !tx_empty;
         default: ;
      endcase
   end

   // ---------------- RX path ----------------
   rx_state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]     rx_baud_q, rx_baud_d;
   logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [1:0]           rx_sync_q, rx_sync_d;
   logic                 rx_line;
   logic                 rx_done;
   logic                 rx_full;
   logic                 rx_good;
   logic                 rx_push;
   logic                 set_frame;
   logic                 set_overrun;
   logic                 set_parity;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_PARITY_EN
   logic                 rx_bad_q, rx_bad_d;
   logic                 rx_par_bad;
   logic                 parity_err_q, parity_err_d;
`endif

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_write (rx_push),
      .i_wdata (rx_shift_q),
      .i_read  (i_rx_read),
      .o_rdata (o_rx_data),
      .o_full  (rx_full),
      .o_empty (o_rx_empty)
   );

   assign rx_sync_d   = {rx_sync_q[0], i_rx_w};
   assign rx_line     = rx_sync_q[1];
   assign rx_done     = (rx_baud_q == '0);
   assign set_overrun = rx_push && rx_full && !i_rx_read;
`ifdef UART_PARITY_EN
   assign rx_par_bad  = rx_line != ((^rx_shift_q) ^ PAR_SENSE);
   assign rx_good     = !rx_bad_q;
`else
   assign rx_good     = 1'b1;
`endif

   // Synchroniser, RX state register and datapath flops; line idles high.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_sync_q  <= 2'b11;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_sync_q  <= rx_sync_d;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // RX next state: half-bit delay to the start-bit centre, then full-bit steps.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
`ifdef UART_PARITY_EN
      rx_bad_d   = rx_bad_q;
`endif
      if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT) rx_baud_d = rx_baud_q - CNT_W'(1);
      case (rx_state_q)
         RX_IDLE: if (!rx_line) begin
            rx_state_d = RX_START;
            rx_baud_d  = HALF_RELOAD;
            rx_bit_d   = '0;
`ifdef UART_PARITY_EN
            rx_bad_d   = 1'b0;
`endif
         end
         RX_START: if (rx_done) begin
            rx_state_d = rx_line ? RX_IDLE : RX_DATA;
            rx_baud_d  = BIT_RELOAD;
         end
         RX_DATA: if (rx_done) begin
            rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
            rx_baud_d  = BIT_RELOAD;
            if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
               rx_state_d = RX_PARITY;
`else
               rx_state_d = RX_STOP;
`endif
            end else begin
               rx_bit_d = rx_bit_q + BIT_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: if (rx_done) begin
            rx_bad_d   = rx_par_bad;
            rx_state_d = RX_STOP;
            rx_baud_d  = BIT_RELOAD;
         end
`endif
         RX_STOP: if (rx_done) rx_state_d = rx_line ? RX_IDLE : RX_WAIT;
         RX_WAIT: if (rx_line) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX outputs: FIFO push and error set events.
   always_comb begin
      rx_push    = 1'b0;
      set_frame  = 1'b0;
      set_parity = 1'b0;
      case (rx_state_q)
`ifdef UART_PARITY_EN
         RX_PARITY: set_parity = rx_done && rx_par_bad;
`endif
         RX_STOP: if (rx_done) begin
            rx_push   = rx_line && rx_good;
            set_frame = !rx_line;
         end
         default: ;
      endcase
   end

   // Sticky error flags: a set event beats a simultaneous clear.
   always_comb begin
      frame_err_d = i_err_clr ? 1'b0 : frame_err_q;
      overrun_d   = i_err_clr ? 1'b0 : overrun_q;
      if (set_frame)   frame_err_d = 1'b1;
      if (set_overrun) overrun_d   = 1'b1;
`ifdef UART_PARITY_EN
      parity_err_d = i_err_clr ? 1'b0 : parity_err_q;
      if (set_parity) parity_err_d = 1'b1;
`endif
   end

   // Sticky error flag registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

`ifdef UART_PARITY_EN
   // Parity flops: TX parity bit, RX bad-frame marker and parity error flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tx_par_q     <= 1'b0;
         rx_bad_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         tx_par_q     <= tx_par_d;
         rx_bad_q     <= rx_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign o_parity_err = parity_err_q;
`else
   assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core (DATA_BITS=8, CYCLES_PER_BIT=4, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_core;
   localparam int DB    = 8;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int FB      = DB + 3;
   localparam int PAR_POS = DB + 1;
`else
   localparam int FB      = DB + 2;
   localparam int PAR_POS = -1;
`endif
   localparam int FRAME_CLKS = FB * CPB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [DB-1:0] tx_data = '0;
   logic         tx_write = 1'b0;
   logic         tx_full, tx_idle;
   logic [DB-1:0] rx_data;
   logic         rx_read = 1'b0;
   logic         rx_empty;
   logic         err_clr = 1'b0;
   logic         frame_err, overrun, parity_err;
   logic         tx_w, rx_w;
   logic         loop_en = 1'b0;
   logic         rx_drv = 1'b1;
   logic         seen_frame_err;

   int n_vec = 0;
   int n_err = 0;
   logic [DB-1:0] rx_model [$];

   assign rx_w = loop_en ? tx_w : rx_drv;

   always #5 clk = ~clk;

   uart_core #(
      .DATA_BITS(DB), .CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_tx_data(tx_data), .i_tx_write(tx_write),
      .o_tx_full(tx_full), .o_tx_idle(tx_idle),
      .o_rx_data(rx_data), .i_rx_read(rx_read), .o_rx_empty(rx_empty),
      .i_err_clr(err_clr),
      .o_frame_err(frame_err), .o_overrun(overrun), .o_parity_err(parity_err),
      .o_tx_w(tx_w), .i_rx_w(rx_w)
   );

   // Reference: line level of bit slot pos in a frame carrying d (even parity).
   function automatic logic frame_bit(input logic [DB-1:0] d, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= DB) return d[pos-1];
      if (pos == PAR_POS) return ^d;
      return 1'b1;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_tx_idle();
      int k = 0;
      while (!tx_idle && k < 5000) begin
         tick();
         k++;
      end
      n_vec++;
      if (tx_idle !== 1'b1) begin
         n_err++;
         $display("FAIL tx_idle_timeout: got %b expected 1", tx_idle);
      end
   endtask

   task automatic push_byte(input logic [DB-1:0] d);
      int k = 0;
      while (tx_full && k < 5000) begin
         tick();
         k++;
      end
      tx_data  = d;
      tx_write = 1'b1;
      tick();
      tx_write = 1'b0;
   endtask

   task automatic pop_check(input logic [DB-1:0] exp);
      n_vec++;
      if (rx_empty !== 1'b0 || rx_data !== exp) begin
         n_err++;
         $display("FAIL rx_pop: got empty=%b data=%h expected empty=0 data=%h", rx_empty, rx_data, exp);
      end
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
   endtask

   // Drive one frame on the RX line by hand; records any o_frame_err pulse.
   task automatic drive_rx_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_flip);
      logic b;
      for (int pos = 0; pos < FB; pos++) begin
         b = (pos == FB - 1) ? stop_bit : frame_bit(d, pos);
         if (pos == PAR_POS) b = b ^ par_flip;
         rx_drv = b;
         repeat (CPB) begin
            tick();
            if (frame_err) seen_frame_err = 1'b1;
         end
      end
      rx_drv = 1'b1;
      repeat (3 * CPB) begin
         tick();
         if (frame_err) seen_frame_err = 1'b1;
      end
   endtask

   // Push one byte and compare the line, clock by clock, with the reference frame.
   task automatic send_and_check(input logic [DB-1:0] d);
      push_byte(d);
      n_vec++;
      if (tx_w !== 1'b1 || tx_idle !== 1'b0) begin
         n_err++;
         $display("FAIL tx_pre_start: got line=%b idle=%b expected line=1 idle=0", tx_w, tx_idle);
      end
      tick();
      for (int c = 0; c < FRAME_CLKS; c++) begin
         n_vec++;
         if (tx_w !== frame_bit(d, c / CPB)) begin
            n_err++;
            $display("FAIL tx_frame_%h clk %0d: got %b expected %b", d, c, tx_w, frame_bit(d, c / CPB));
         end
         tick();
      end
      n_vec++;
      if (tx_w !== 1'b1 || tx_idle !== 1'b1) begin
         n_err++;
         $display("FAIL tx_post_frame: got line=%b idle=%b expected line=1 idle=1", tx_w, tx_idle);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      n_vec++;
      if ({tx_full, rx_empty, tx_idle, tx_w} !== 4'b0111) begin
         n_err++;
         $display("FAIL reset_status: got full,empty,idle,line=%b expected 0111", {tx_full, rx_empty, tx_idle, tx_w});
      end
      n_vec++;
      if (rx_data !== '0) begin
         n_err++;
         $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      end
      n_vec++;
      if ({frame_err, overrun, parity_err} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 000", {frame_err, overrun, parity_err});
      end
   endtask

   task automatic test_reset_mid_frame();
      logic stayed_high = 1'b1;
      push_byte(8'h00);
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (tx_w !== 1'b1 || tx_idle !== 1'b1 || tx_full !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort: got line=%b idle=%b full=%b expected 1 1 0", tx_w, tx_idle, tx_full);
      end
      tick();
      rst = 1'b0;
      repeat (FRAME_CLKS) begin
         tick();
         if (tx_w !== 1'b1) stayed_high = 1'b0;
      end
      n_vec++;
      if (stayed_high !== 1'b1) begin
         n_err++;
         $display("FAIL reset_no_resume: got %b expected 1", stayed_high);
      end
   endtask

   task automatic test_single_frame();
      send_and_check(8'hA5);
      send_and_check(8'($urandom));
   endtask

   task automatic test_back_to_back();
      logic [DB-1:0] fr [5];
      wait_tx_idle();
      fr[0] = 8'($urandom);
      for (int i = 1; i < 5; i++) fr[i] = 8'(i);
      tx_data  = fr[0];
      tx_write = 1'b1;
      tick();
      tx_write = 1'b0;
      tick();
      fork
         begin
            // 0x01..0x05 pushed on consecutive cycles while the first frame is on the line.
            tick();
            for (int i = 0; i < 5; i++) begin
               n_vec++;
               if (tx_full !== 1'(i == 4)) begin
                  n_err++;
                  $display("FAIL tx_full_step%0d: got %b expected %b", i, tx_full, 1'(i == 4));
               end
               tx_data  = 8'(i + 1);
               tx_write = 1'b1;
               tick();
            end
            tx_write = 1'b0;
            n_vec++;
            if (tx_full !== 1'b1) begin
               n_err++;
               $display("FAIL tx_full_after_drop: got %b expected 1", tx_full);
            end
         end
         begin
            for (int c = 0; c < 5 * FRAME_CLKS; c++) begin
               n_vec++;
               if (tx_w !== frame_bit(fr[c / FRAME_CLKS], (c % FRAME_CLKS) / CPB)) begin
                  n_err++;
                  $display("FAIL b2b_line clk %0d: got %b expected %b", c, tx_w,
                           frame_bit(fr[c / FRAME_CLKS], (c % FRAME_CLKS) / CPB));
               end
               tick();
            end
            n_vec++;
            if (tx_w !== 1'b1 || tx_idle !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_idle_after: got line=%b idle=%b expected 1 1", tx_w, tx_idle);
            end
         end
      join
   endtask

   task automatic test_loopback();
      logic [DB-1:0] b;
      loop_en = 1'b1;
      push_byte(8'h3C);
      push_byte(8'hC3);
      wait_tx_idle();
      repeat (3 * CPB) tick();
      pop_check(8'h3C);
      pop_check(8'hC3);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         rx_model.push_back(b);
         push_byte(b);
      end
      wait_tx_idle();
      repeat (3 * CPB) tick();
      while (rx_model.size() > 0) pop_check(rx_model.pop_front());
      n_vec++;
      if (rx_empty !== 1'b1 || {frame_err, overrun, parity_err} !== 3'b000) begin
         n_err++;
         $display("FAIL loopback_clean: got empty=%b flags=%b expected 1 000", rx_empty, {frame_err, overrun, parity_err});
      end
      loop_en = 1'b0;
   endtask

   task automatic test_frame_error();
      logic [DB-1:0] b;
      seen_frame_err = 1'b0;
      drive_rx_frame(8'h55, 1'b0, 1'b0);
      n_vec++;
      if (frame_err !== 1'b1 || rx_empty !== 1'b1) begin
         n_err++;
         $display("FAIL frame_err_set: got err=%b empty=%b expected 1 1", frame_err, rx_empty);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_vec++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL frame_err_clr: got %b expected 0", frame_err);
      end
      // Receiver must re-arm after the bad frame.
      b = 8'($urandom);
      drive_rx_frame(b, 1'b1, 1'b0);
      pop_check(b);
      // Clear held high throughout: the set event still shows for a cycle.
      seen_frame_err = 1'b0;
      err_clr = 1'b1;
      drive_rx_frame(8'($urandom), 1'b0, 1'b0);
      err_clr = 1'b0;
      n_vec++;
      if (seen_frame_err !== 1'b1 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL set_beats_clr: got seen=%b final=%b expected 1 0", seen_frame_err, frame_err);
      end
   endtask

   task automatic test_glitch();
      rx_drv = 1'b0;
      tick();
      rx_drv = 1'b1;
      repeat (5 * CPB) tick();
      n_vec++;
      if (rx_empty !== 1'b1 || {frame_err, overrun, parity_err} !== 3'b000) begin
         n_err++;
         $display("FAIL glitch_ignored: got empty=%b flags=%b expected 1 000", rx_empty, {frame_err, overrun, parity_err});
      end
   endtask

   task automatic test_overrun();
      logic [DB-1:0] b;
      logic exp_ovr = 1'b0;
      loop_en = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         if (rx_model.size() < DEPTH) rx_model.push_back(b);
         else exp_ovr = 1'b1;
         push_byte(b);
      end
      wait_tx_idle();
      repeat (3 * CPB) tick();
      n_vec++;
      if (overrun !== exp_ovr) begin
         n_err++;
         $display("FAIL overrun_set: got %b expected %b", overrun, exp_ovr);
      end
      while (rx_model.size() > 0) pop_check(rx_model.pop_front());
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_vec++;
      if (overrun !== 1'b0 || rx_empty !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_clr: got ovr=%b empty=%b expected 0 1", overrun, rx_empty);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_parity();
`ifdef UART_PARITY_EN
      send_and_check(8'h07);
      drive_rx_frame(8'h07, 1'b1, 1'b1);
      n_vec++;
      if (parity_err !== 1'b1 || rx_empty !== 1'b1 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL parity_err: got perr=%b empty=%b ferr=%b expected 1 1 0", parity_err, rx_empty, frame_err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
`endif
      n_vec++;
      if (parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL parity_flag_final: got %b expected 0", parity_err);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_frame();
      test_single_frame();
      test_back_to_back();
      test_loopback();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_parity();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex, parametrised UART: buffered TX and RX paths sharing one clock domain. Successor to the TX-only UART top.
- TX path: a write-side push interface feeds a TX FIFO, which feeds a serialiser.
- RX path: a synchroniser and mid-bit sampler feed an RX FIFO with a show-ahead read interface.
- Adds framing and overrun error detection. The FIFOs are internal and self-contained.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- CYCLES_PER_BIT, 108, clocks per bit (>=4); 460.8 kBaud at 50 MHz.
- FIFO_DEPTH, 8, entries per FIFO; power of 2, >=2.
- PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_tx_data  in  DATA_BITS  byte to transmit
- i_tx_write  in  1  push i_tx_data into TX FIFO
- o_tx_full  out  1  TX FIFO full
- o_tx_idle  out  1  TX FIFO empty and serialiser idle
- o_rx_data  out  DATA_BITS  head of RX FIFO (show-ahead)
- i_rx_read  in  1  pop RX FIFO
- o_rx_empty  out  1  RX FIFO empty
- i_err_clr  in  1  clear sticky error flags
- o_frame_err  out  1  sticky: stop bit sampled low
- o_overrun  out  1  sticky: byte received while RX FIFO full
- o_parity_err  out  1  sticky: parity mismatch (tied 0 without UART_PARITY_EN)
- o_tx_w  out  1  serial line out
- i_rx_w  in  1  serial line in (asynchronous)

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty, so o_tx_full=0, o_rx_empty=1, o_tx_idle=1.
  - o_rx_data=0, all error flags 0.
  - o_tx_w=1; both FSMs in IDLE; synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural.
  - Write when full is ignored. Read when empty is ignored.
  - Simultaneous read and write: both take effect and the count is unchanged. This includes the full case (the read frees a slot) and the empty case (the write is accepted, the read is ignored).
  - Write data is visible at the head on the next cycle.
- Baud counter: counts CYCLES_PER_BIT-1 down to 0. Each bit lasts exactly CYCLES_PER_BIT clocks.
- TX FSM (IDLE, START, DATA, [PARITY], STOP):
  - IDLE with TX FIFO non-empty: pop the head into the shift register. START drives 0 from the next cycle.
  - DATA shifts LSB first for DATA_BITS bits.
  - STOP drives 1 for one bit, then returns to IDLE.
  - Back-to-back bytes: the next START follows STOP with no idle gap.
  - Frame length = (DATA_BITS+2[+1]) * CYCLES_PER_BIT clocks.
- RX front end: i_rx_w passes through a 2-flop synchroniser (2 clocks of latency).
- RX FSM (IDLE, START, DATA, [PARITY], STOP):
  - IDLE on synchronised low: enter START and wait CYCLES_PER_BIT/2.
  - START sample low: continue. Sample high: glitch, return to IDLE with no error.
  - DATA samples every CYCLES_PER_BIT at mid-bit, LSB first.
  - STOP sample high: push the byte into the RX FIFO. If the FIFO is full (read not asserted in the same cycle), drop the byte and set o_overrun.
  - STOP sample low: set o_frame_err and discard the byte. Wait for the line to go high before re-arming in IDLE.
- Sticky flags: i_err_clr clears them. A set event in the same cycle as i_err_clr wins.
- o_tx_idle = TX FIFO empty AND TX FSM in IDLE.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - TX inserts a parity bit after the data: XOR of the data bits, XOR PARITY_ODD.
  - RX samples the parity bit. On mismatch it sets o_parity_err and discards the byte (a good stop bit is still required to re-arm).
- Undefined:
  - No parity state and no parity bit on the line.
  - o_parity_err is constant 0.

Test Plan (CYCLES_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4):
- Write 0xA5 once -> o_tx_w: start 0, then 1,0,1,0,0,1,0,1 (LSB first), then stop 1. Each level holds 4 clocks; 40 clocks total; o_tx_idle returns 1 afterwards.
- Write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles -> o_tx_full asserts after the 4th push is registered. With no pop yet, 0x05 is dropped and 0x01..0x04 are sent back-to-back with no idle gaps.
- Loop o_tx_w to i_rx_w; send 0x3C, 0xC3 -> o_rx_empty deasserts; o_rx_data reads 0x3C then 0xC3 across two i_rx_read pops; no error flags set.
- Drive i_rx_w with a frame for 0x55 whose stop bit is 0 -> o_frame_err=1, FIFO stays empty. i_err_clr pulse -> flag returns to 0.
- Loop back 5 bytes with no reads -> the first 4 are stored, the 5th sets o_overrun. A 1-clock low glitch on an idle line -> no byte and no error.
- With UART_PARITY_EN and PARITY_ODD=0, send 0x07 -> parity bit 1 on the line. Inject 0x07 with parity 0 -> o_parity_err=1 and no byte stored.
